// File: rtl/fbcpu_memory.sv
// fbcpu_memory: word RAM answering the FB-CPU memory bus, with a stream program loader
// that holds the core in reset while it fills memory from word 0 upwards.
module fbcpu_memory #(
   parameter int ADDRESS_WIDTH = 6,
   parameter int DATA_WIDTH    = 10,
   parameter int LOAD_WORDS    = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDRESS_WIDTH-1:0] MAR,
   input  logic                     RAMWr,
   input  logic [DATA_WIDTH-1:0]    MDRIn,
   output logic [DATA_WIDTH-1:0]    MDROut,
   input  logic                     load_start,
   input  logic                     load_valid,
   input  logic [DATA_WIDTH-1:0]    load_data,
   input  logic                     load_last,
   output logic                     load_ready,
   output logic                     load_busy,
   output logic                     load_done,
   output logic [ADDRESS_WIDTH:0]   load_count,
   output logic                     cpu_rst
);
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
   localparam logic [ADDRESS_WIDTH:0] LAST_IDX = (ADDRESS_WIDTH+1)'(LOAD_WORDS - 1);
   state_t                   state_q, state_d;
   logic [ADDRESS_WIDTH:0]   count_q, count_d;
   logic [DATA_WIDTH-1:0]    mdr_q, mdr_d;
   logic [DATA_WIDTH-1:0]    mem [0:(2**ADDRESS_WIDTH)-1];
   logic                     we;
   logic [ADDRESS_WIDTH-1:0] waddr;
   logic [DATA_WIDTH-1:0]    wdata;
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      mdr_d   = '0;
      we      = 1'b0;
      waddr   = MAR;
      wdata   = MDRIn;
      case (state_q)
         IDLE: begin
            mdr_d = mem[MAR];
            we    = RAMWr;
            if (load_start) begin
               state_d = LOAD;
               count_d = '0;
            end
         end
         LOAD: begin
            we    = load_valid;
            waddr = count_q[ADDRESS_WIDTH-1:0];
            wdata = load_data;
            if (load_valid) begin
               count_d = count_q + 1'b1;
               if (load_last || count_q == LAST_IDX) state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // RAM itself is never reset; its read is registered into mdr_q (read-first)
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         mdr_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         mdr_q   <= mdr_d;
      end
   end
   assign MDROut     = mdr_q;
   assign load_ready = state_q == LOAD;
   assign load_busy  = state_q == LOAD;
   assign load_done  = state_q == DONE;
   assign load_count = count_q;
   assign cpu_rst    = rst || state_q != IDLE;
endmodule

// File: tb/tb_fbcpu_memory.sv
// tb_fbcpu_memory: directed stimulus, a spec-level reference model compared every cycle,
// and literal expectations for the loader, CPU port, async reset and a tiny program run.
module tb_fbcpu_memory;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] MAR = '0;
   logic       RAMWr = 1'b0;
   logic [9:0] MDRIn = '0;
   logic [9:0] MDROut;
   logic       load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
   logic [9:0] load_data = '0;
   logic       load_ready, load_busy, load_done, cpu_rst;
   logic [6:0] load_count;
   int n_chk = 0, n_fail = 0;

   fbcpu_memory dut (
      .clk(clk), .rst(rst), .MAR(MAR), .RAMWr(RAMWr), .MDRIn(MDRIn), .MDROut(MDROut),
      .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
      .load_last(load_last), .load_ready(load_ready), .load_busy(load_busy),
      .load_done(load_done), .load_count(load_count), .cpu_rst(cpu_rst)
   );

   always #5 clk = ~clk;

   // mode: 0 = CPU owns memory, 1 = loading, 2 = done pulse
   int         m_mode = 0;
   int         m_cnt = 0;
   logic [9:0] m_mem [64];
   bit         m_known [64];
   logic [9:0] m_mdr = '0;
   bit         m_mdr_ok = 1'b1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode = 0;
         m_cnt = 0;
         m_mdr = '0;
         m_mdr_ok = 1'b1;
      end else if (m_mode == 0) begin
         m_mdr = m_mem[MAR];
         m_mdr_ok = m_known[MAR];
         if (RAMWr) begin
            m_mem[MAR] = MDRIn;
            m_known[MAR] = 1'b1;
         end
         if (load_start) begin
            m_mode = 1;
            m_cnt = 0;
         end
      end else if (m_mode == 1) begin
         m_mdr = '0;
         m_mdr_ok = 1'b1;
         if (load_valid) begin
            m_mem[m_cnt] = load_data;
            m_known[m_cnt] = 1'b1;
            m_cnt++;
            if (load_last || m_cnt == 64) m_mode = 2;
         end
      end else begin
         m_mdr = '0;
         m_mdr_ok = 1'b1;
         m_mode = 0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("busy", 32'(load_busy), 32'(m_mode == 1));
      chk("ready", 32'(load_ready), 32'(m_mode == 1));
      chk("done", 32'(load_done), 32'(m_mode == 2));
      chk("cpu_rst", 32'(cpu_rst), 32'(rst || m_mode != 0));
      chk("count", 32'(load_count), 32'(m_cnt));
      if (m_mdr_ok) chk("mdrout", 32'(MDROut), 32'(m_mdr));
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [9:0] d, input logic last);
      load_valid = 1'b1;
      load_data = d;
      load_last = last;
      tick();
      load_valid = 1'b0;
      load_last = 1'b0;
   endtask

   task automatic start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic rd(input logic [5:0] a, input logic [9:0] exp);
      MAR = a;
      tick();
      chk("readback", 32'(MDROut), 32'(exp));
   endtask

   logic [9:0] prog [12];
   logic [9:0] ir, acc;
   int pc;
   bit halted;

   initial begin
      tick();
      tick();
      chk("rst_cpu_rst", 32'(cpu_rst), 32'h1);
      chk("rst_mdr", 32'(MDROut), 32'h0);
      chk("rst_count", 32'(load_count), 32'h0);
      rst = 1'b0;
      tick();
      chk("idle_cpu_rst", 32'(cpu_rst), 32'h0);
      // preload 13 words, mem[5]=2A3, mem[12]=055
      start();
      chk("load_busy", 32'(load_busy), 32'h1);
      chk("load_cpu_rst", 32'(cpu_rst), 32'h1);
      for (int i = 0; i < 13; i++) send(i == 5 ? 10'h2A3 : 10'(i * 7 + 1), i == 12);
      chk("a_done", 32'(load_done), 32'h1);
      chk("a_count", 32'(load_count), 32'd13);
      MAR = 6'd5;
      tick();
      chk("a_mdr_before", 32'(MDROut), 32'h0);
      chk("a_cpu_rst_low", 32'(cpu_rst), 32'h0);
      tick();
      chk("a_mdr5", 32'(MDROut), 32'h2A3);
      // CPU write is read-first
      MAR = 6'd12;
      MDRIn = 10'h155;
      RAMWr = 1'b1;
      tick();
      RAMWr = 1'b0;
      chk("b_old", 32'(MDROut), 32'h055);
      tick();
      chk("b_new", 32'(MDROut), 32'h155);
      // loader with gaps, simultaneous CPU write on the start edge
      MAR = 6'd20;
      MDRIn = 10'h0AA;
      RAMWr = 1'b1;
      start();
      RAMWr = 1'b0;
      send(10'h001, 1'b0);
      tick();
      send(10'h182, 1'b0);
      tick();
      tick();
      send(10'h3FF, 1'b1);
      chk("c_done", 32'(load_done), 32'h1);
      chk("c_count", 32'(load_count), 32'd3);
      chk("c_cpu_rst", 32'(cpu_rst), 32'h1);
      tick();
      chk("c_done_once", 32'(load_done), 32'h0);
      chk("c_cpu_rst_low", 32'(cpu_rst), 32'h0);
      chk("c_count_hold", 32'(load_count), 32'd3);
      rd(6'd0, 10'h001);
      rd(6'd1, 10'h182);
      rd(6'd2, 10'h3FF);
      rd(6'd20, 10'h0AA);
      rd(6'd3, 10'h016);
      // full-depth load without load_last
      start();
      for (int i = 0; i < 64; i++) send(10'(i * 5 + 3), 1'b0);
      chk("d_done", 32'(load_done), 32'h1);
      chk("d_count", 32'(load_count), 32'd64);
      chk("d_ready", 32'(load_ready), 32'h0);
      send(10'h3FF, 1'b0);
      chk("d_ready_after", 32'(load_ready), 32'h0);
      chk("d_count_after", 32'(load_count), 32'd64);
      rd(6'd0, 10'd3);
      rd(6'd63, 10'd318);
      rd(6'd2, 10'd13);
      // async reset mid-load
      start();
      send(10'h0F0, 1'b0);
      send(10'h0F1, 1'b0);
      MAR = 6'd30;
      MDRIn = 10'h111;
      RAMWr = 1'b1;
      tick();
      RAMWr = 1'b0;
      chk("e_busy_pre", 32'(load_busy), 32'h1);
      #1 rst = 1'b1;
      #1;
      chk("e_busy", 32'(load_busy), 32'h0);
      chk("e_ready", 32'(load_ready), 32'h0);
      chk("e_count", 32'(load_count), 32'h0);
      chk("e_mdr", 32'(MDROut), 32'h0);
      chk("e_cpu_rst", 32'(cpu_rst), 32'h1);
      rst = 1'b0;
      tick();
      chk("e_idle", 32'(cpu_rst), 32'h0);
      rd(6'd0, 10'h0F0);
      rd(6'd1, 10'h0F1);
      rd(6'd30, 10'd153);
      rd(6'd2, 10'd13);
      // program: LOAD 10, ADD 11, STORE 12, HALT; opcode in [9:6], address in [5:0]
      for (int i = 0; i < 12; i++) prog[i] = '0;
      prog[0] = 10'h04A;
      prog[1] = 10'h08B;
      prog[2] = 10'h0CC;
      prog[3] = 10'h3C0;
      prog[10] = 10'd3;
      prog[11] = 10'd4;
      start();
      for (int i = 0; i < 12; i++) send(prog[i], i == 11);
      tick();
      chk("f_cpu_rst_low", 32'(cpu_rst), 32'h0);
      pc = 0;
      acc = '0;
      halted = 1'b0;
      for (int s = 0; s < 8 && !halted; s++) begin
         MAR = 6'(pc);
         tick();
         ir = MDROut;
         pc++;
         if (ir[9:6] == 4'h1 || ir[9:6] == 4'h2) begin
            MAR = ir[5:0];
            tick();
            acc = (ir[9:6] == 4'h1) ? MDROut : acc + MDROut;
         end else if (ir[9:6] == 4'h3) begin
            MAR = ir[5:0];
            MDRIn = acc;
            RAMWr = 1'b1;
            tick();
            RAMWr = 1'b0;
         end else halted = 1'b1;
      end
      chk("f_halted", 32'(halted), 32'h1);
      rd(6'd12, 10'd7);
      tick();
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
